// File: rtl/load_updown_counter.sv
// rtl/load_updown_counter.sv - loadable modulo up/down counter with clock-enable prescaler
// Optional saturation mode: define LOAD_UPDOWN_COUNTER_SAT_EN to add the sat input.
module load_updown_counter #(
   parameter int          WIDTH    = 8,
   parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
   parameter int          PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             en,
   input  logic             up_dn,
`ifdef LOAD_UPDOWN_COUNTER_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAX_W  = MAX_VAL[WIDTH-1:0];
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             wrap_q, wrap_d;
   logic             pre_last;
   logic             at_top;
   logic             at_bottom;

   assign pre_last  = (pre_q == PRE_LAST);
   assign at_top    = (cnt_q == MAX_W);
   assign at_bottom = (cnt_q == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         pre_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pre_q  <= pre_d;
         wrap_q <= wrap_d;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      pre_d  = pre_q;
      wrap_d = 1'b0;
      if (load) begin
         cnt_d = (data_in > MAX_W) ? MAX_W : data_in;
         pre_d = '0;
      end else if (en) begin
         pre_d = pre_last ? '0 : pre_q + PW'(1);
         if (pre_last) begin
            // Out-of-range values (q > MAX_VAL) recover to 0 going up, MAX_VAL going down.
            if (up_dn) begin
               cnt_d  = (cnt_q >= MAX_W) ? '0 : cnt_q + WIDTH'(1);
               wrap_d = at_top;
            end else begin
               cnt_d  = (at_bottom || cnt_q > MAX_W) ? MAX_W : cnt_q - WIDTH'(1);
               wrap_d = at_bottom;
            end
`ifdef LOAD_UPDOWN_COUNTER_SAT_EN
            if (sat && (up_dn ? at_top : at_bottom)) begin
               cnt_d  = cnt_q;
               wrap_d = 1'b0;
            end
`endif
         end
      end
   end

   assign q    = cnt_q;
   assign wrap = wrap_q;
   assign tc   = up_dn ? at_top : at_bottom;

endmodule

// File: tb/tb_load_updown_counter.sv
// tb/tb_load_updown_counter.sv - randomized check of load_updown_counter against a modulo arithmetic model
// Two instances (PRESCALE 1 and 3, WIDTH 4, MAX_VAL 9) share stimulus.
module tb_load_updown_counter;

   localparam int MAXV = 9;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] data_in;
   logic       en;
   logic       up_dn;
   logic       sat;
   logic [3:0] q0, q1;
   logic       tc0, tc1, wrap0, wrap1;

   int total = 0;
   int bad   = 0;
   int mq[2];
   int mp[2];
   int mw[2];
   int presc[2] = '{1, 3};

   always #5 clk = ~clk;

   load_updown_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(1)) dut0 (
      .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en), .up_dn(up_dn),
`ifdef LOAD_UPDOWN_COUNTER_SAT_EN
      .sat(sat),
`endif
      .q(q0), .tc(tc0), .wrap(wrap0));

   load_updown_counter #(.WIDTH(4), .MAX_VAL(MAXV), .PRESCALE(3)) dut1 (
      .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en), .up_dn(up_dn),
`ifdef LOAD_UPDOWN_COUNTER_SAT_EN
      .sat(sat),
`endif
      .q(q1), .tc(tc1), .wrap(wrap1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit sat_active();
`ifdef LOAD_UPDOWN_COUNTER_SAT_EN
      return sat;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k] = 0;
         mp[k] = 0;
         mw[k] = 0;
      end
   endtask

   // Reference: value space is the integers 0..MAXV, stepping is modular arithmetic.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            mq[k] = 0; mp[k] = 0; mw[k] = 0;
         end else if (load) begin
            mq[k] = (int'(data_in) > MAXV) ? MAXV : int'(data_in);
            mp[k] = 0;
            mw[k] = 0;
         end else if (en) begin
            mw[k] = 0;
            if (mp[k] == presc[k] - 1) begin
               mp[k] = 0;
               if (up_dn) begin
                  if (!(sat_active() && mq[k] == MAXV)) begin
                     mw[k] = (mq[k] == MAXV);
                     mq[k] = (mq[k] + 1) % (MAXV + 1);
                  end
               end else begin
                  if (!(sat_active() && mq[k] == 0)) begin
                     mw[k] = (mq[k] == 0);
                     mq[k] = (mq[k] + MAXV) % (MAXV + 1);
                  end
               end
            end else begin
               mp[k] = mp[k] + 1;
            end
         end else begin
            mw[k] = 0;
         end
      end
   endtask

   task automatic compare_all();
      int etc0, etc1;
      etc0 = up_dn ? (mq[0] == MAXV) : (mq[0] == 0);
      etc1 = up_dn ? (mq[1] == MAXV) : (mq[1] == 0);
      check("q0", 32'(q0), mq[0]);
      check("wrap0", 32'(wrap0), mw[0]);
      check("tc0", 32'(tc0), etc0);
      check("q1", 32'(q1), mq[1]);
      check("wrap1", 32'(wrap1), mw[1]);
      check("tc1", 32'(tc1), etc1);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b0; load = 1'b0; data_in = '0; en = 1'b0; up_dn = 1'b1; sat = 1'b0;
      model_reset();
      cycle();
      cycle();
      check("reset_q", 32'(q0), 0);
      check("reset_wrap", 32'(wrap0), 0);
      rst = 1'b1;

      // async reset mid-count at q=5
      load = 1'b1; data_in = 4'd5;
      cycle();
      load = 1'b0; en = 1'b0;
      check("load5_q", 32'(q0), 5);
      up_dn = 1'b0;
      rst = 1'b0;
      #2;
      model_reset();
      check("async_rst_q", 32'(q0), 0);
      check("async_rst_wrap", 32'(wrap0), 0);
      check("async_rst_tc", 32'(tc0), 1);
      cycle();
      rst = 1'b1;

      // up wrap 7,8,9,0,1
      load = 1'b1; data_in = 4'd7; en = 1'b1; up_dn = 1'b1;
      cycle();
      load = 1'b0;
      cycle();
      cycle();
      check("up_tc_at9", 32'(tc0), 1);
      cycle();
      check("up_wrap_q", 32'(q0), 0);
      check("up_wrap_pulse", 32'(wrap0), 1);
      cycle();
      check("up_after_wrap", 32'(wrap0), 0);

      // clamp and down wrap
      load = 1'b1; data_in = 4'hF; up_dn = 1'b0;
      cycle();
      check("clamp_q", 32'(q0), 9);
      load = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      check("down_wrap_q", 32'(q0), 9);
      check("down_wrap_pulse", 32'(wrap0), 1);

      // prescale 3 with en gap of 2 cycles
      load = 1'b1; data_in = 4'd0; up_dn = 1'b1;
      cycle();
      load = 1'b0; en = 1'b1;
      cycle();
      cycle();
      check("pre_hold", 32'(q1), 0);
      en = 1'b0;
      cycle();
      cycle();
      check("pre_frozen", 32'(q1), 0);
      en = 1'b1;
      cycle();
      check("pre_step", 32'(q1), 1);

      // load beats a terminal-count step
      load = 1'b1; data_in = 4'd9;
      cycle();
      load = 1'b1; data_in = 4'd3;
      cycle();
      check("ldpri_q", 32'(q0), 3);
      check("ldpri_wrap", 32'(wrap0), 0);
      load = 1'b0;
      cycle();
      cycle();
      check("ldpri_pre_q1", 32'(q1), 3);
      cycle();
      check("ldpri_pre_step", 32'(q1), 4);

`ifdef LOAD_UPDOWN_COUNTER_SAT_EN
      load = 1'b1; data_in = 4'd9;
      cycle();
      load = 1'b0; sat = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      check("sat_q", 32'(q0), 9);
      check("sat_wrap", 32'(wrap0), 0);
      sat = 1'b0;
      cycle();
      check("unsat_q", 32'(q0), 0);
      check("unsat_wrap", 32'(wrap0), 1);
`endif

      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 99) != 0);
         load    = ($urandom_range(0, 9) == 0);
         data_in = 4'($urandom_range(0, 15));
         en      = ($urandom_range(0, 3) != 0);
         up_dn   = ($urandom_range(0, 4) != 0) ? up_dn : ~up_dn;
         sat     = ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
